fmul_arbiter: RTL

Round-robin arbiter and sequencer that shares one combinational floating-point multiplier among `NUM_REQ` requesters in the CNN datapath. It grants one requester at a time, registers its operands into the multiplier, captures the product, and returns it with the requester's index over a valid/ready response channel. It sits between the convolution lane controllers and the single multiplier instance, and drives that instance's `A`/`B` inputs and samples its `C` output.

---
 rtl/fmul_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one combinational FP multiplier.
// Grants one requester, registers operands, returns the product with its id.
module fmul_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0]         mul_a,
  output logic [DATA_WIDTH-1:0]         mul_b,
  input  logic [DATA_WIDTH-1:0]         mul_c,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [ID_WIDTH-1:0]   op_id_q, op_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;

  logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];
  logic [ID_WIDTH-1:0]   gnt;
  logic                  gnt_vld;
  logic                  accept;
  logic                  xfer;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping; scanned in
  // reverse so the last hit is the nearest one.
  always_comb begin
    int                  sum;
    logic [ID_WIDTH-1:0] idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_WIDTH'(sum);
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign accept = (state_q == IDLE) ||
                  ((state_q == RESP) && rsp_ready);
  assign xfer   = accept && gnt_vld;

  // Ready only toward the granted requester when a slot is free.
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt] = 1'b1;
  end

  // Next-state: sequencing plus operand capture on transfer.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_id_d    = op_id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    unique case (state_q)
      IDLE: state_d = IDLE;
      MUL: begin
        rsp_data_d = mul_c;
        rsp_id_d   = op_id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      op_a_d   = a_arr[gnt];
      op_b_d   = b_arr[gnt];
      op_id_d  = gnt;
      rr_ptr_d = ID_WIDTH'((int'(gnt) + 1) % NUM_REQ);
      state_d  = MUL;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_id_q    <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_id_q    <= op_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule
